pc_seq_ctrl: RTL and testbench
==============================

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 The module SHALL have port clk50m, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have port cmd_valid, input, 1 bit: command request from the initiator.
REQ-004 The module SHALL have port cmd_ready, output, 1 bit: module can accept a command this cycle.
REQ-005 The module SHALL have port cmd_op, input, 3 bits: 000 NOP, 001 STEP_UP, 010 STEP_DN, 011 JUMP, 100 CALL, 101 RET, 110 RUN_UP, 111 RUN_DN.
REQ-006 The module SHALL have port cmd_arg, input, 10 bits: jump/call target, or run length for RUN_UP/RUN_DN.
REQ-007 The module SHALL have port pc, input, 10 bits: current program-counter value fed back from the counter.
REQ-008 The module SHALL have port en, output, 1 bit: count enable to the counter.
REQ-009 The module SHALL have port load, output, 1 bit: parallel load strobe to the counter.
REQ-010 The module SHALL have port updn, output, 1 bit: direction to the counter; 0 = up, 1 = down.
REQ-011 The module SHALL have port data_in, output, 10 bits: load value to the counter.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The module SHALL have port err, output, 1 bit: sticky flag for return-stack overflow or underflow.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_op, cmd_arg and pc SHALL be sampled on that edge.
REQ-015 The FSM SHALL have exactly three states:
- IDLE: cmd_ready=1.
- ISSUE: one cycle, drives a single-cycle op.
- RUN: multi-cycle count.
REQ-016 All control outputs (en, load, updn, data_in, busy) SHALL be registered; the first effect of an accepted command SHALL appear in the cycle after acceptance.
REQ-017 Accepting NOP SHALL leave the FSM in IDLE and keep en=0 and load=0.
REQ-018 STEP_UP SHALL give IDLE->ISSUE with en=1, updn=0 for exactly one cycle, then ISSUE->IDLE.
REQ-019 STEP_DN SHALL behave like STEP_UP but with updn=1.
REQ-020 JUMP SHALL drive ISSUE with load=1 and data_in=cmd_arg for one cycle.
REQ-021 CALL SHALL push pc+1 (10-bit wrap, 1023->0) onto the return stack and drive ISSUE with load=1 and data_in=cmd_arg.
REQ-022 RET SHALL pop the top of the return stack and drive ISSUE with load=1 and data_in=the popped value.
REQ-023 RUN_UP with cmd_arg=N>0 SHALL enter RUN and hold en=1, updn=0 for exactly N consecutive cycles using an internal 10-bit down-counter, then return to IDLE.
REQ-024 RUN_DN SHALL behave like RUN_UP but with updn=1.
REQ-025 RUN_UP or RUN_DN with cmd_arg=0 SHALL behave as NOP.
REQ-026 cmd_ready SHALL be 0 in ISSUE and RUN, and SHALL return to 1 in the cycle after the last en or load cycle.
REQ-027 load and en SHALL never be 1 in the same cycle.
REQ-028 When neither en nor load is 1, data_in SHALL hold its last value and updn SHALL be 0.
REQ-029 The return stack SHALL be a LIFO of 4 entries x 10 bits.
REQ-030 CALL with the stack full SHALL push nothing and load nothing (en=0, load=0 for that ISSUE cycle), and SHALL set err.
REQ-031 RET with the stack empty SHALL load nothing and SHALL set err.
REQ-032 err SHALL stay set until reset; commands SHALL continue to be processed while err=1.
REQ-033 pc changes during RUN SHALL be ignored; pc is used only at CALL acceptance.

Reset
REQ-034 While rst_n=0: en=0, load=0, updn=0, data_in=0, busy=0, err=0, cmd_ready=0; FSM=IDLE; stack empty; run counter=0.
REQ-035 cmd_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-036 Reset asserted mid-RUN or mid-ISSUE SHALL drop en and load immediately (asynchronously), and no partial operation SHALL resume after reset.

Verification
REQ-037 JUMP arg=0x155 accepted at edge k -> load=1, data_in=0x155 in cycle k+1 only; cmd_ready=1 at k+2.
REQ-038 pc=0x3FF, CALL 0x010, then RET -> first load 0x010; RET load 0x000 (wrap); err=0.
REQ-039 Five CALLs with no RET -> fifth CALL produces no load and err=1; four following RETs pop in LIFO order; a fifth RET produces no load.
REQ-040 RUN_DN arg=3 -> en=1, updn=1 for exactly 3 cycles; cmd_ready=0 throughout; arg=0 -> no en pulse.
REQ-041 rst_n low during cycle 2 of RUN_UP arg=10 -> en=0 asynchronously; after release: busy=0, err=0, stack empty (RET sets err).

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: turns step/jump/call/return/run commands into
// registered en/load/updn/data_in strobes for an external 10-bit counter.
module pc_seq_ctrl (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [9:0] cmd_arg,
    input  logic [9:0] pc,
    output logic       en,
    output logic       load,
    output logic       updn,
    output logic [9:0] data_in,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_STEPUP = 3'b001,
        OP_STEPDN = 3'b010,
        OP_JUMP   = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101,
        OP_RUNUP  = 3'b110,
        OP_RUNDN  = 3'b111
    } op_t;

    state_t     state, state_nxt;
    logic [9:0] run_cnt, cnt_nxt;
    logic [9:0] stack [4];
    logic [2:0] sp;
    logic [1:0] sp_top;
    logic       push, pop;
    logic       en_nxt, load_nxt, updn_nxt, err_nxt;
    logic [9:0] data_nxt;

    assign sp_top = sp[1:0] - 2'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = run_cnt;
        en_nxt    = 1'b0;
        load_nxt  = 1'b0;
        updn_nxt  = 1'b0;
        data_nxt  = data_in;
        err_nxt   = err;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (op_t'(cmd_op))
                        OP_STEPUP: begin
                            state_nxt = ISSUE;
                            en_nxt    = 1'b1;
                        end
                        OP_STEPDN: begin
                            state_nxt = ISSUE;
                            en_nxt    = 1'b1;
                            updn_nxt  = 1'b1;
                        end
                        OP_JUMP: begin
                            state_nxt = ISSUE;
                            load_nxt  = 1'b1;
                            data_nxt  = cmd_arg;
                        end
                        OP_CALL: begin
                            state_nxt = ISSUE;
                            if (sp == 3'd4) begin
                                err_nxt = 1'b1;
                            end else begin
                                push     = 1'b1;
                                load_nxt = 1'b1;
                                data_nxt = cmd_arg;
                            end
                        end
                        OP_RET: begin
                            state_nxt = ISSUE;
                            if (sp == 3'd0) begin
                                err_nxt = 1'b1;
                            end else begin
                                pop      = 1'b1;
                                load_nxt = 1'b1;
                                data_nxt = stack[sp_top];
                            end
                        end
                        OP_RUNUP, OP_RUNDN: begin
                            // run_cnt counts the en cycles still owed after the first one
                            if (cmd_arg != '0) begin
                                state_nxt = RUN;
                                en_nxt    = 1'b1;
                                updn_nxt  = cmd_op[0];
                                cnt_nxt   = cmd_arg - 10'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ISSUE: state_nxt = IDLE;
            RUN: begin
                if (run_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    en_nxt   = 1'b1;
                    updn_nxt = updn;
                    cnt_nxt  = run_cnt - 10'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_cnt   <= '0;
            cmd_ready <= 1'b0;
            en        <= 1'b0;
            load      <= 1'b0;
            updn      <= 1'b0;
            data_in   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            sp        <= '0;
            for (int unsigned i = 0; i < 4; i++) stack[i] <= '0;
        end else begin
            state     <= state_nxt;
            run_cnt   <= cnt_nxt;
            cmd_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            en        <= en_nxt;
            load      <= load_nxt;
            updn      <= updn_nxt;
            data_in   <= data_nxt;
            err       <= err_nxt;
            if (push) begin
                stack[sp[1:0]] <= pc + 10'd1;
                sp             <= sp + 3'd1;
            end else if (pop) begin
                sp <= sp - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: expected en/load pulses are queued when a
// command is driven and matched in order as the DUT emits them.
module tb_pc_seq_ctrl;

    logic       clk50m = 1'b0;
    logic       rst_n  = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op  = '0;
    logic [9:0] cmd_arg = '0;
    logic [9:0] pc      = '0;
    logic       en, load, updn, busy, err;
    logic [9:0] data_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [12:0] sb [$];
    logic [9:0]  mstk [$];
    logic        exp_err  = 1'b0;
    logic [9:0]  exp_data = '0;

    pc_seq_ctrl dut (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_arg  (cmd_arg),
        .pc       (pc),
        .en       (en),
        .load     (load),
        .updn     (updn),
        .data_in  (data_in),
        .busy     (busy),
        .err      (err)
    );

    always #10 clk50m = ~clk50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor: every en/load cycle must match the head of the scoreboard
    always @(negedge clk50m) begin
        logic [12:0] obs, e;
        if (rst_n) begin
            obs = {load, en, updn, (load ? data_in : 10'd0)};
            if (en || load) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'(obs), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse", 32'(obs), 32'(e));
                    if (e[12]) exp_data = e[9:0];
                end
            end else begin
                check("updn_idle", 32'(updn), 32'd0);
            end
            if (!load) check("data_hold", 32'(data_in), 32'(exp_data));
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk50m);
            t++;
        end
        if (t >= 100) check("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [9:0] arg, input logic [9:0] pcv);
        int len;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        pc        = pcv;
        len       = 1;
        case (op)
            3'd0: len = 0;
            3'd1: sb.push_back({1'b0, 1'b1, 1'b0, 10'd0});
            3'd2: sb.push_back({1'b0, 1'b1, 1'b1, 10'd0});
            3'd3: sb.push_back({1'b1, 1'b0, 1'b0, arg});
            3'd4: begin
                if (mstk.size() == 4) exp_err = 1'b1;
                else begin
                    mstk.push_back(pcv + 10'd1);
                    sb.push_back({1'b1, 1'b0, 1'b0, arg});
                end
            end
            3'd5: begin
                if (mstk.size() == 0) exp_err = 1'b1;
                else sb.push_back({1'b1, 1'b0, 1'b0, mstk.pop_back()});
            end
            default: begin
                len = int'(arg);
                for (int i = 0; i < len; i++) sb.push_back({1'b0, 1'b1, op[0], 10'd0});
            end
        endcase
        @(posedge clk50m);
        #1;
        cmd_valid = 1'b0;
        pc        = 10'($urandom);
        for (int i = 0; i < len; i++) begin
            @(negedge clk50m);
            check("busy_active", 32'(busy), 32'd1);
            check("ready_low", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk50m);
        check("ready_back", 32'(cmd_ready), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("err", 32'(err), 32'(exp_err));
    endtask

    task automatic clear_model();
        sb.delete();
        mstk.delete();
        exp_err  = 1'b0;
        exp_data = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #25;
        check("rst_en", 32'(en), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data_in), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        #30 rst_n = 1'b1;
        @(posedge clk50m);
        #1 check("ready_first_edge", 32'(cmd_ready), 32'd1);
        @(negedge clk50m);

        do_cmd(3'd3, 10'h155, 10'h000);     // JUMP
        do_cmd(3'd0, 10'h3AA, 10'h000);     // NOP
        do_cmd(3'd1, 10'h000, 10'h000);     // STEP_UP
        do_cmd(3'd2, 10'h000, 10'h000);     // STEP_DN
        do_cmd(3'd4, 10'h010, 10'h3FF);     // CALL from 0x3FF
        do_cmd(3'd5, 10'h000, 10'h000);     // RET -> 0x000
        check("err_after_wrap", 32'(err), 32'd0);

        for (int i = 0; i < 5; i++) do_cmd(3'd4, 10'(i * 37 + 5), 10'(100 * i + 1));
        check("err_overflow", 32'(err), 32'd1);
        for (int i = 0; i < 5; i++) do_cmd(3'd5, 10'($urandom), 10'($urandom));

        do_cmd(3'd7, 10'd3, 10'h000);       // RUN_DN 3
        do_cmd(3'd6, 10'd0, 10'h000);       // RUN_UP 0
        do_cmd(3'd7, 10'd0, 10'h000);       // RUN_DN 0
        do_cmd(3'd6, 10'd5, 10'h000);
        do_cmd(3'd7, 10'd1, 10'h000);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            do_cmd(op, (op[2] && op[1]) ? 10'($urandom_range(0, 6)) : 10'($urandom),
                   10'($urandom));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        // reset in the middle of RUN_UP 10
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_arg   = 10'd10;
        for (int i = 0; i < 10; i++) sb.push_back({1'b0, 1'b1, 1'b0, 10'd0});
        @(posedge clk50m);
        #1 cmd_valid = 1'b0;
        @(negedge clk50m);
        @(negedge clk50m);
        check("run_en_before_rst", 32'(en), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_en", 32'(en), 32'd0);
        check("rst_async_load", 32'(load), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_ready", 32'(cmd_ready), 32'd0);
        clear_model();
        @(negedge clk50m);
        #2 rst_n = 1'b1;
        @(negedge clk50m);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_en", 32'(en), 32'd0);
        @(negedge clk50m);
        check("no_resume_en", 32'(en), 32'd0);
        do_cmd(3'd5, 10'h000, 10'h000);     // RET on empty stack
        check("empty_ret_err", 32'(err), 32'd1);
        do_cmd(3'd1, 10'h000, 10'h000);     // still processes with err set
        @(negedge clk50m);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
